// File: rtl/captura_pkg.sv
// Shared types and default parameters for the operand-capture stage of the
// 16-bit word concatenator.
package captura_pkg;

  typedef enum logic {
    ESPERA_1 = 1'b0,
    ESPERA_2 = 1'b1
  } estado_t;

  localparam int WIDTH_DEF          = 8;
  localparam int TIMEOUT_CYCLES_DEF = 100000;

endpackage : captura_pkg

// File: rtl/contador_timeout.sv
// Saturating cycle counter: restarts on clr, advances on en, and raises a
// registered done flag while it sits on its terminal value.
module contador_timeout #(
  parameter int TERMINAL = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int              CW   = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
  localparam logic [CW-1:0]   LAST = CW'(TERMINAL - 1);

  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;

  // next count: restart, advance, or hold at the terminal value
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {CW{1'b0}};
    end else if (en && (count_q != LAST)) begin
      count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
    done_d = (count_d == LAST);
  end

  // counter and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= {CW{1'b0}};
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule : contador_timeout

// File: rtl/captura_operandos.sv
// Pairs byte strobes into an (op_1, op_2) operand pair, updated atomically,
// with a timeout that discards a first byte whose partner arrives too late.
module captura_operandos
  import captura_pkg::*;
#(
  parameter int WIDTH          = WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] byte_in,
  input  logic             byte_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] op_1,
  output logic [WIDTH-1:0] op_2,
  output logic             pair_valid,
  output logic             waiting_2nd,
  output logic             timeout_err
);

  estado_t          state_q, state_d;
  logic [WIDTH-1:0] staging_q, staging_d;
  logic [WIDTH-1:0] op_1_q, op_1_d;
  logic [WIDTH-1:0] op_2_q, op_2_d;
  logic             pair_valid_q, pair_valid_d;
  logic             timeout_err_q, timeout_err_d;
  logic             waiting_2nd_q, waiting_2nd_d;
  logic             cnt_clr_s, cnt_en_s, cnt_done_s;

  // the counter restarts on every accepted first byte and runs only while waiting
  assign cnt_clr_s = (state_q == ESPERA_1) && byte_valid && !clear;
  assign cnt_en_s  = (state_q == ESPERA_2);

  contador_timeout #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_contador (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr_s),
    .en    (cnt_en_s),
    .done  (cnt_done_s)
  );

  // next state and output values; clear beats a strobe, a strobe beats the timeout
  always_comb begin
    state_d       = state_q;
    staging_d     = staging_q;
    op_1_d        = op_1_q;
    op_2_d        = op_2_q;
    pair_valid_d  = 1'b0;
    timeout_err_d = 1'b0;
    case (state_q)
      ESPERA_1: begin
        if (!clear && byte_valid) begin
          staging_d = byte_in;
          state_d   = ESPERA_2;
        end else begin
          state_d   = ESPERA_1;
        end
      end
      ESPERA_2: begin
        if (clear) begin
          staging_d = {WIDTH{1'b0}};
          state_d   = ESPERA_1;
        end else if (byte_valid) begin
          op_1_d       = staging_q;
          op_2_d       = byte_in;
          pair_valid_d = 1'b1;
          state_d      = ESPERA_1;
        end else if (cnt_done_s) begin
          timeout_err_d = 1'b1;
          state_d       = ESPERA_1;
        end else begin
          state_d = ESPERA_2;
        end
      end
      default: begin
        state_d = ESPERA_1;
      end
    endcase
    waiting_2nd_d = (state_d == ESPERA_2);
  end

  // state, staging and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ESPERA_1;
      staging_q     <= {WIDTH{1'b0}};
      op_1_q        <= {WIDTH{1'b0}};
      op_2_q        <= {WIDTH{1'b0}};
      pair_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      waiting_2nd_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      staging_q     <= staging_d;
      op_1_q        <= op_1_d;
      op_2_q        <= op_2_d;
      pair_valid_q  <= pair_valid_d;
      timeout_err_q <= timeout_err_d;
      waiting_2nd_q <= waiting_2nd_d;
    end
  end

  assign op_1        = op_1_q;
  assign op_2        = op_2_q;
  assign pair_valid  = pair_valid_q;
  assign waiting_2nd = waiting_2nd_q;
  assign timeout_err = timeout_err_q;

endmodule : captura_operandos

// File: tb/tb_captura_operandos.sv
// Directed and randomized bench for captura_operandos against a queue-based
// pairing model with a 16-cycle timeout.
module tb_captura_operandos;

  localparam int W = 8;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] byte_in;
  logic         byte_valid;
  logic         clear;
  logic [W-1:0] op_1, op_2;
  logic         pair_valid, waiting_2nd, timeout_err;

  always #5 clk = ~clk;

  captura_operandos #(
    .WIDTH          (W),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .clear       (clear),
    .op_1        (op_1),
    .op_2        (op_2),
    .pair_valid  (pair_valid),
    .waiting_2nd (waiting_2nd),
    .timeout_err (timeout_err)
  );

  int tests = 0;
  int fails = 0;

  // reference model: a queue holding an unpaired first byte and its age in cycles
  logic [W-1:0] pend[$];
  int           elapsed;
  logic [W-1:0] m_op1, m_op2;
  logic         m_pv, m_terr;
  int           n_pairs, n_timeouts;

  task automatic model_reset();
    pend.delete();
    elapsed = 0;
    m_op1 = '0; m_op2 = '0; m_pv = 1'b0; m_terr = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [W-1:0] b, input logic c);
    m_pv = 1'b0;
    m_terr = 1'b0;
    if (pend.size() != 0) begin
      elapsed++;
      if (c) pend.delete();
      else if (v) begin
        m_op1 = pend.pop_front();
        m_op2 = b;
        m_pv = 1'b1;
        n_pairs++;
      end else if (elapsed >= T) begin
        pend.delete();
        m_terr = 1'b1;
        n_timeouts++;
      end
    end else if (v && !c) begin
      pend.push_back(b);
      elapsed = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".op_1"}, {8'h00, op_1}, {8'h00, m_op1});
    chk({tag, ".op_2"}, {8'h00, op_2}, {8'h00, m_op2});
    chk({tag, ".pair_valid"}, {15'h0000, pair_valid}, {15'h0000, m_pv});
    chk({tag, ".timeout_err"}, {15'h0000, timeout_err}, {15'h0000, m_terr});
    chk({tag, ".waiting_2nd"}, {15'h0000, waiting_2nd}, {15'h0000, (pend.size() != 0)});
  endtask

  task automatic step(input string tag, input logic v, input logic [W-1:0] b, input logic c);
    byte_valid = v;
    byte_in    = b;
    clear      = c;
    @(posedge clk);
    model_edge(v, b, c);
    #1;
    check_all(tag);
    byte_valid = 1'b0;
    clear      = 1'b0;
  endtask

  initial begin
    int pv_seen;
    int te_seen;
    n_pairs = 0;
    n_timeouts = 0;
    reset = 1'b1; byte_valid = 1'b0; clear = 1'b0; byte_in = 8'h00;
    model_reset();
    #12;
    reset = 1'b0;
    #1;
    check_all("reset_init");

    // single pair, 4 cycles apart
    step("pair_b1", 1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 3; i++) step("pair_gap", 1'b0, 8'h00, 1'b0);
    step("pair_b2", 1'b1, 8'h3C, 1'b0);
    chk("pair_word", {op_1, op_2}, 16'hA53C);
    step("pair_after", 1'b0, 8'h00, 1'b0);

    // async reset while holding a first byte
    step("rst_b1", 1'b1, 8'h5A, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("reset_mid");
    #10;
    reset = 1'b0;
    step("rst_after", 1'b0, 8'h00, 1'b0);

    // back-to-back strobes
    pv_seen = 0;
    step("b2b_1", 1'b1, 8'h01, 1'b0);
    step("b2b_2", 1'b1, 8'h02, 1'b0);
    pv_seen += int'(pair_valid);
    chk("b2b_pair1", {op_1, op_2}, 16'h0102);
    step("b2b_3", 1'b1, 8'h03, 1'b0);
    pv_seen += int'(pair_valid);
    step("b2b_4", 1'b1, 8'h04, 1'b0);
    pv_seen += int'(pair_valid);
    chk("b2b_pair2", {op_1, op_2}, 16'h0304);
    step("b2b_idle", 1'b0, 8'h00, 1'b0);
    pv_seen += int'(pair_valid);
    chk("b2b_count", 16'(pv_seen), 16'd2);

    // timeout: no second byte for T cycles
    te_seen = 0;
    step("to_b1", 1'b1, 8'h11, 1'b0);
    for (int i = 0; i < T; i++) begin
      step("to_wait", 1'b0, 8'h00, 1'b0);
      te_seen += int'(timeout_err);
    end
    step("to_idle", 1'b0, 8'h00, 1'b0);
    te_seen += int'(timeout_err);
    chk("to_count", 16'(te_seen), 16'd1);
    chk("to_ops_held", {op_1, op_2}, 16'h0304);
    step("to_n1", 1'b1, 8'h22, 1'b0);
    step("to_n2", 1'b1, 8'h33, 1'b0);
    chk("to_next", {op_1, op_2}, 16'h2233);

    // second byte exactly on the terminal cycle
    step("bnd_b1", 1'b1, 8'h44, 1'b0);
    for (int i = 0; i < T - 1; i++) step("bnd_wait", 1'b0, 8'h00, 1'b0);
    step("bnd_b2", 1'b1, 8'h77, 1'b0);
    chk("bnd_pv", {15'h0000, pair_valid}, 16'h0001);
    chk("bnd_te", {15'h0000, timeout_err}, 16'h0000);
    chk("bnd_word", {op_1, op_2}, 16'h4477);
    step("bnd_after", 1'b0, 8'h00, 1'b0);

    // clear with a simultaneous strobe
    step("clr_b1", 1'b1, 8'h55, 1'b0);
    step("clr_hit", 1'b1, 8'h66, 1'b1);
    chk("clr_pv", {15'h0000, pair_valid}, 16'h0000);
    step("clr_idle", 1'b0, 8'h00, 1'b0);
    step("clr_n1", 1'b1, 8'h88, 1'b0);
    step("clr_n2", 1'b1, 8'h99, 1'b0);
    chk("clr_next", {op_1, op_2}, 16'h8899);
    step("clr_e1", 1'b1, 8'hC3, 1'b1);

    // randomized traffic including long silences around the timeout
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        int gap;
        gap = $urandom_range(T - 3, T + 2);
        step("rnd_b1", 1'b1, W'($urandom), 1'b0);
        for (int g = 0; g < gap; g++) step("rnd_gap", 1'b0, 8'h00, 1'b0);
      end else begin
        step("rnd", ($urandom_range(0, 99) < 40), W'($urandom), ($urandom_range(0, 99) < 5));
      end
    end
    chk("rnd_pairs_seen", 16'(n_pairs > 10), 16'd1);
    chk("rnd_timeouts_seen", 16'(n_timeouts > 2), 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_captura_operandos
